// File: rtl/mseq_pkg.sv
// Shared definitions for the 4-bit M-sequence generator and synchronizer.
//   LFSR_W       : LFSR width
//   TAPS_DEFAULT : default feedback tap mask (x^4 + x^3 + 1, period 15)
//   sync_state_e : synchronizer state encoding
//   lfsr_next()  : one LFSR step, new bit enters at bit 0
package mseq_pkg;

  localparam int unsigned LFSR_W = 4;
  localparam logic [LFSR_W-1:0] TAPS_DEFAULT = 4'b1001;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } sync_state_e;

  // Shift left, feedback bit = XOR of the tapped state bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state,
                                                   input logic [LFSR_W-1:0] taps);
    return {state[LFSR_W-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/mseq_sync_if.sv
// Serial bit stream carried from the line side into the synchronizer.
//   in_bit   : received serial bit
//   in_valid : one-cycle strobe qualifying in_bit
//   master   : drives the stream; slave : consumes it
interface mseq_sync_if;

  logic in_bit;
  logic in_valid;

  modport master (output in_bit, output in_valid);
  modport slave  (input  in_bit, input  in_valid);

endinterface

// File: rtl/mseq_step.sv
// Combinational LFSR step: predicted bit and the two candidate next windows.
//   i_phase      : current 4-bit window (oldest bit in bit 3)
//   i_bit        : received bit
//   o_exp_bit_c  : predicted next bit
//   o_match_c    : received bit equals prediction
//   o_flywheel_c : window advanced with the predicted bit
//   o_shift_c    : window advanced with the received bit
module mseq_step
  import mseq_pkg::*;
#(
  parameter logic [LFSR_W-1:0] TAPS = TAPS_DEFAULT
) (
  input  logic [LFSR_W-1:0] i_phase,
  input  logic              i_bit,
  output logic              o_exp_bit_c,
  output logic              o_match_c,
  output logic [LFSR_W-1:0] o_flywheel_c,
  output logic [LFSR_W-1:0] o_shift_c
);

  assign o_flywheel_c = lfsr_next(i_phase, TAPS);
  assign o_exp_bit_c  = o_flywheel_c[0];
  assign o_shift_c    = {i_phase[LFSR_W-2:0], i_bit};
  assign o_match_c    = (i_bit == o_exp_bit_c);

endmodule

// File: rtl/mseq_sync.sv
// Serial M-sequence synchronizer: hunts the LFSR window from the incoming
// bits, verifies it over LOCK_N predictions, then flywheels while tracking
// mispredictions.
//   CLK_50MHZ : system clock, rising edge
//   RST       : synchronous active-high reset
//   s_in      : serial bit stream (in_bit / in_valid)
//   locked    : high while in LOCK
//   phase     : local LFSR window (oldest bit in bit 3)
//   exp_bit   : predicted next bit, combinational from phase
//   bit_err   : one-cycle pulse on a misprediction while locked
//   err_cnt   : saturating count of locked mispredictions
//   epoch     : one-cycle pulse when, locked, phase advances to all-ones
module mseq_sync
  import mseq_pkg::*;
#(
  parameter logic [LFSR_W-1:0] TAPS   = TAPS_DEFAULT,
  parameter int unsigned       LOCK_N = 8,
  parameter int unsigned       MISS_N = 3,
  parameter int unsigned       ERR_W  = 16
) (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  mseq_sync_if.slave        s_in,
  output logic              locked,
  output logic [LFSR_W-1:0] phase,
  output logic              exp_bit,
  output logic              bit_err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              epoch
);

  localparam int unsigned HUNT_W = 3;
  localparam int unsigned CNT_W  = 4;
  localparam logic [HUNT_W-1:0] HUNT_FULL = HUNT_W'(LFSR_W);

  sync_state_e       r_state;
  logic [HUNT_W-1:0] r_hunt_cnt;
  logic [CNT_W-1:0]  r_match_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;
  logic [LFSR_W-1:0] r_phase;
  logic              r_locked;
  logic              r_bit_err;
  logic              r_epoch;
  logic [ERR_W-1:0]  r_err_cnt;

  logic              w_exp_bit;
  logic              w_match;
  logic [LFSR_W-1:0] w_flywheel;
  logic [LFSR_W-1:0] w_shift;

  mseq_step #(.TAPS(TAPS)) u_step (
    .i_phase      (r_phase),
    .i_bit        (s_in.in_bit),
    .o_exp_bit_c  (w_exp_bit),
    .o_match_c    (w_match),
    .o_flywheel_c (w_flywheel),
    .o_shift_c    (w_shift)
  );

  // Acquisition / tracking FSM with its counters and registered outputs.
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      r_state     <= HUNT;
      r_hunt_cnt  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_phase     <= '0;
      r_locked    <= 1'b0;
      r_bit_err   <= 1'b0;
      r_epoch     <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_bit_err <= 1'b0;
      r_epoch   <= 1'b0;
      if (s_in.in_valid) begin
        case (r_state)
          HUNT: begin
            r_phase <= w_shift;
            if (r_hunt_cnt != HUNT_FULL) r_hunt_cnt <= r_hunt_cnt + HUNT_W'(1);
            // Window is complete once this bit brings the count to four;
            // the all-zero lockup window is never accepted.
            if ((r_hunt_cnt >= HUNT_FULL - HUNT_W'(1)) && (w_shift != '0)) begin
              r_state     <= VERIFY;
              r_match_cnt <= '0;
            end
          end
          VERIFY: begin
            if (w_match) begin
              r_phase     <= w_flywheel;
              r_match_cnt <= r_match_cnt + CNT_W'(1);
              if (r_match_cnt == CNT_W'(LOCK_N - 1)) begin
                r_state    <= LOCK;
                r_locked   <= 1'b1;
                r_miss_cnt <= '0;
              end
            end else begin
              // Offending bit is dropped; hunting restarts from an empty window.
              r_state    <= HUNT;
              r_hunt_cnt <= '0;
            end
          end
          LOCK: begin
            r_phase <= w_flywheel;
            r_epoch <= (w_flywheel == '1);
            if (!w_match) begin
              r_bit_err <= 1'b1;
              if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
              if (r_miss_cnt == CNT_W'(MISS_N - 1)) begin
                r_state    <= HUNT;
                r_hunt_cnt <= '0;
                r_locked   <= 1'b0;
                r_miss_cnt <= '0;
              end else begin
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
              end
            end else begin
              r_miss_cnt <= '0;
            end
          end
          default: begin
            r_state <= HUNT;
          end
        endcase
      end
    end
  end

  assign locked  = r_locked;
  assign phase   = r_phase;
  assign exp_bit = w_exp_bit;
  assign bit_err = r_bit_err;
  assign err_cnt = r_err_cnt;
  assign epoch   = r_epoch;

endmodule

// File: tb/tb_mseq_sync.sv
// Self-checking bench for mseq_sync: behavioural reference model feeding a
// scoreboard of expected outputs, plus scenario-level checks.
module tb_mseq_sync;
  import mseq_pkg::*;

  localparam int unsigned LOCK_N = 8;
  localparam int unsigned MISS_N = 3;
  localparam int unsigned ERR_W  = 16;
  localparam logic [3:0]  TB_TAPS = 4'b1001;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  mseq_sync_if bus ();

  logic             locked;
  logic [3:0]       phase;
  logic             exp_bit;
  logic             bit_err;
  logic [ERR_W-1:0] err_cnt;
  logic             epoch;

  mseq_sync #(.TAPS(TB_TAPS), .LOCK_N(LOCK_N), .MISS_N(MISS_N), .ERR_W(ERR_W)) dut (
    .CLK_50MHZ (clk),
    .RST       (rst),
    .s_in      (bus),
    .locked    (locked),
    .phase     (phase),
    .exp_bit   (exp_bit),
    .bit_err   (bit_err),
    .err_cnt   (err_cnt),
    .epoch     (epoch)
  );

  typedef struct packed {
    logic             locked;
    logic [3:0]       phase;
    logic             exp_bit;
    logic             bit_err;
    logic [ERR_W-1:0] err_cnt;
    logic             epoch;
  } obs_t;

  obs_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int               m_st;      // 0 hunt, 1 verify, 2 lock
  int               m_hunt, m_match, m_miss;
  logic [3:0]       m_phase;
  logic [ERR_W-1:0] m_err;

  // Generator and observation bookkeeping
  logic [3:0] gen;
  logic [3:0] gen_hist[$];
  int         bit_idx;
  int         lock_idx, unlock_idx, n_biterr;
  int         epoch_idx[$];
  logic       prev_locked;

  function automatic obs_t model_obs(input logic be, input logic ep);
    obs_t o;
    o.locked  = (m_st == 2);
    o.phase   = m_phase;
    o.exp_bit = ^(m_phase & TB_TAPS);
    o.bit_err = be;
    o.err_cnt = m_err;
    o.epoch   = ep;
    return o;
  endfunction

  task automatic model_valid(input logic b);
    logic be, ep, pred;
    be = 1'b0; ep = 1'b0;
    pred = ^(m_phase & TB_TAPS);
    case (m_st)
      0: begin
        m_phase = {m_phase[2:0], b};
        if (m_hunt < 4) m_hunt++;
        if (m_hunt == 4 && m_phase != 4'b0000) begin m_st = 1; m_match = 0; end
      end
      1: begin
        if (b == pred) begin
          m_phase = {m_phase[2:0], pred};
          m_match++;
          if (m_match == int'(LOCK_N)) begin m_st = 2; m_miss = 0; end
        end else begin
          m_st = 0; m_hunt = 0;
        end
      end
      default: begin
        m_phase = {m_phase[2:0], pred};
        if (b != pred) begin
          be = 1'b1;
          if (m_err != {ERR_W{1'b1}}) m_err = m_err + 1'b1;
          m_miss++;
          if (m_miss == int'(MISS_N)) begin m_st = 0; m_hunt = 0; end
        end else begin
          m_miss = 0;
        end
        ep = (m_phase == 4'b1111);
      end
    endcase
    sb_q.push_back(model_obs(be, ep));
  endtask

  // One clock: drive, push expectation, sample after the edge and score it.
  task automatic cycle(input logic v, input logic b);
    obs_t got, want;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_bit   = b;
    if (v) begin
      bit_idx++;
      model_valid(b);
    end else begin
      sb_q.push_back(model_obs(1'b0, 1'b0));
    end
    @(posedge clk);
    #1;
    got  = {locked, phase, exp_bit, bit_err, err_cnt, epoch};
    want = sb_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL scoreboard bit=%0d valid=%0b: got lk=%0b ph=%h eb=%0b be=%0b ec=%0d ep=%0b expected lk=%0b ph=%h eb=%0b be=%0b ec=%0d ep=%0b",
               bit_idx, v, got.locked, got.phase, got.exp_bit, got.bit_err, got.err_cnt, got.epoch,
               want.locked, want.phase, want.exp_bit, want.bit_err, want.err_cnt, want.epoch);
    end
    if (v) begin
      if (locked && !prev_locked) lock_idx = bit_idx;
      if (!locked && prev_locked) unlock_idx = bit_idx;
      if (bit_err) n_biterr++;
      if (epoch) epoch_idx.push_back(bit_idx);
      prev_locked = locked;
    end
  endtask

  // Send n generator bits, flipping those whose index lies in [flo, fhi].
  task automatic run_stream(input int n, input int flo, input int fhi, input int gaps);
    logic b;
    for (int k = 0; k < n; k++) begin
      gen_hist.push_back(gen);
      b   = gen[3];
      gen = lfsr_next(gen, TB_TAPS);
      if ((bit_idx + 1) >= flo && (bit_idx + 1) <= fhi) b = ~b;
      cycle(1'b1, b);
      for (int g = 0; g < gaps; g++) cycle(1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  // Reset with a valid strobe on the same edge; RST must win.
  task automatic test_reset();
    obs_t got;
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    @(posedge clk);
    #1;
    got = {locked, phase, exp_bit, bit_err, err_cnt, epoch};
    checks++;
    if (got !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", got, obs_t'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    m_st = 0; m_hunt = 0; m_match = 0; m_miss = 0; m_phase = '0; m_err = '0;
    sb_q.delete();
    gen = 4'b0101;
    gen_hist.delete();
    epoch_idx.delete();
    bit_idx = 0; lock_idx = -1; unlock_idx = -1; n_biterr = 0; prev_locked = 1'b0;
  endtask

  task automatic test_acquire(input int gaps);
    int bad_phase;
    test_reset();
    bad_phase = 0;
    for (int k = 0; k < 45; k++) begin
      run_stream(1, 0, 0, gaps);
      if (locked && phase !== gen_hist[bit_idx-4]) bad_phase++;
    end
    checks++;
    if (lock_idx != 12) begin
      errors++; $display("FAIL acquire_lock_bit gaps=%0d: got %0d expected 12", gaps, lock_idx);
    end
    checks++;
    if (bad_phase != 0) begin
      errors++; $display("FAIL acquire_phase_track gaps=%0d: got %0d bad bits expected 0", gaps, bad_phase);
    end
    checks++;
    if (epoch_idx.size() < 2) begin
      errors++; $display("FAIL acquire_epoch_count gaps=%0d: got %0d expected >=2", gaps, epoch_idx.size());
    end
    for (int i = 1; i < epoch_idx.size(); i++) begin
      checks++;
      if (epoch_idx[i] - epoch_idx[i-1] != 15) begin
        errors++; $display("FAIL acquire_epoch_spacing gaps=%0d: got %0d expected 15", gaps, epoch_idx[i] - epoch_idx[i-1]);
      end
    end
    checks++;
    if (err_cnt !== '0) begin
      errors++; $display("FAIL acquire_err_cnt gaps=%0d: got %0d expected 0", gaps, err_cnt);
    end
  endtask

  task automatic test_single_err();
    test_reset();
    run_stream(20, 0, 0, 0);
    run_stream(1, 21, 21, 0);
    checks++;
    if (bit_err !== 1'b1 || err_cnt !== 16'd1 || locked !== 1'b1) begin
      errors++; $display("FAIL single_err_pulse: got be=%0b ec=%0d lk=%0b expected be=1 ec=1 lk=1", bit_err, err_cnt, locked);
    end
    // Alternating good/bad bits only hold lock if the miss counter clears.
    run_stream(1, 0, 0, 0);
    run_stream(1, 23, 23, 0);
    run_stream(1, 0, 0, 0);
    run_stream(1, 25, 25, 0);
    run_stream(5, 0, 0, 0);
    checks++;
    if (locked !== 1'b1 || unlock_idx != -1) begin
      errors++; $display("FAIL single_err_hold_lock: got lk=%0b unlock_bit=%0d expected lk=1 unlock_bit=-1", locked, unlock_idx);
    end
    checks++;
    if (err_cnt !== 16'd3 || n_biterr != 3) begin
      errors++; $display("FAIL single_err_count: got ec=%0d pulses=%0d expected 3 3", err_cnt, n_biterr);
    end
  endtask

  task automatic test_burst();
    test_reset();
    run_stream(22, 21, 23, 0);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL burst_hold_after_2: got %0b expected 1", locked);
    end
    run_stream(1, 21, 23, 0);
    checks++;
    if (unlock_idx != 23 || locked !== 1'b0 || bit_err !== 1'b1) begin
      errors++; $display("FAIL burst_unlock: got bit=%0d lk=%0b be=%0b expected bit=23 lk=0 be=1", unlock_idx, locked, bit_err);
    end
    run_stream(15, 0, 0, 0);
    checks++;
    if (lock_idx != 35) begin
      errors++; $display("FAIL burst_relock_bit: got %0d expected 35", lock_idx);
    end
    checks++;
    if (err_cnt !== 16'd3) begin
      errors++; $display("FAIL burst_err_cnt: got %0d expected 3", err_cnt);
    end
  endtask

  task automatic test_zeros();
    test_reset();
    for (int k = 0; k < 50; k++) cycle(1'b1, 1'b0);
    checks++;
    if (lock_idx != -1 || locked !== 1'b0 || err_cnt !== '0 || phase !== 4'b0000) begin
      errors++; $display("FAIL zeros_stay_hunt: got lock_bit=%0d lk=%0b ec=%0d ph=%h expected -1 0 0 0", lock_idx, locked, err_cnt, phase);
    end
  endtask

  task automatic test_verify_err();
    test_reset();
    run_stream(25, 7, 7, 0);
    checks++;
    if (lock_idx != 19 || locked !== 1'b1) begin
      errors++; $display("FAIL verify_err_relock: got bit=%0d lk=%0b expected bit=19 lk=1", lock_idx, locked);
    end
    checks++;
    if (err_cnt !== '0 || n_biterr != 0) begin
      errors++; $display("FAIL verify_err_no_count: got ec=%0d pulses=%0d expected 0 0", err_cnt, n_biterr);
    end
    test_reset();
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    test_reset();
    test_acquire(0);
    test_acquire(2);
    test_single_err();
    test_burst();
    test_zeros();
    test_verify_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
